// File: rtl/mac_cfg_loader_pkg.sv
// Shared MAC configuration constants and width helpers.
// mac_cluster uses the same conf/acc widths and cfg-bus width formula,
// so both blocks size the cfg bus identically from this one place.
package mac_cfg_loader_pkg;

   // Mode bits: signed, mac/mul, 2-bit Single/Dual/Quad select
   localparam int MAC_CONF_WIDTH_DEF = 4;
   // Accumulator init value width for each of the four blocks
   localparam int MAC_ACC_WIDTH_DEF  = 32;
   // Serial beat width on the loader input
   localparam int BEAT_WIDTH_DEF     = 8;

   // Full cfg bus: four accumulator init words plus the mode bits on top
   function automatic int cfgWidth(input int accWidth, input int confWidth);
      return 4 * accWidth + confWidth;
   endfunction

   // Integer ceiling division, used for the beat count of one frame
   function automatic int ceilDiv(input int num, input int den);
      return (num + den - 1) / den;
   endfunction

endpackage

// File: rtl/mac_cfg_loader.sv
// Serial-to-parallel configuration loader for mac_cluster.
// Collects NBEATS beats (LSB chunk first) into a shadow register and
// commits the whole word to cfg with a single-cycle cset strobe.
// Malformed frames (early or missing in_last) raise a one-cycle err and
// never disturb the committed cfg.
module mac_cfg_loader
   import mac_cfg_loader_pkg::*;
#(
   parameter int MAC_CONF_WIDTH = MAC_CONF_WIDTH_DEF,
   parameter int MAC_ACC_WIDTH  = MAC_ACC_WIDTH_DEF,
   parameter int BEAT_WIDTH     = BEAT_WIDTH_DEF,
   localparam int CFG_WIDTH     = cfgWidth(MAC_ACC_WIDTH, MAC_CONF_WIDTH),
   localparam int NBEATS        = ceilDiv(CFG_WIDTH, BEAT_WIDTH)
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BEAT_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic [CFG_WIDTH-1:0]  cfg,
   output logic                  cset,
   output logic                  busy,
   output logic                  err
);

   localparam int CNT_W = $clog2(NBEATS + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      APPLY = 2'd2,
      DRAIN = 2'd3
   } state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [CFG_WIDTH-1:0] shadow_q;
   logic [CFG_WIDTH-1:0] shadow_d;
   logic [CFG_WIDTH-1:0] cfg_q;
   logic                 cset_q;
   logic                 err_q;

   logic                 acceptBeat;
   logic [CNT_W-1:0]     beatIdx;

   // Ready in every state but APPLY, and never while held in reset or stalled
   assign in_ready   = rst & en & (state_q != APPLY);
   assign acceptBeat = in_valid & in_ready;
   assign beatIdx    = (state_q == IDLE) ? '0 : cnt_q;

   assign cfg  = cfg_q;
   assign cset = cset_q;
   assign err  = err_q;
   assign busy = (state_q != IDLE);

   // Merge the incoming beat into its chunk of the shadow; bits of the last
   // beat that land at or above CFG_WIDTH simply have no home and drop out
   always_comb begin
      shadow_d = shadow_q;
      for (int b = 0; b < CFG_WIDTH; b++) begin
         if ((b / BEAT_WIDTH) == int'(beatIdx)) begin
            shadow_d[b] = in_data[b % BEAT_WIDTH];
         end
      end
   end

   // Frame FSM: beat collection, commit, error handling and drain
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         shadow_q <= '0;
         cfg_q    <= '0;
         cset_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         cset_q <= 1'b0;
         err_q  <= 1'b0;
         if (en) begin
            case (state_q)
               IDLE, LOAD: begin
                  if (acceptBeat) begin
                     if (in_last && (beatIdx != LAST_IDX)) begin
                        err_q    <= 1'b1;
                        shadow_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= IDLE;
                     end else if (beatIdx == LAST_IDX) begin
                        shadow_q <= shadow_d;
                        cnt_q    <= '0;
                        if (in_last) begin
                           state_q <= APPLY;
                        end else begin
                           err_q   <= 1'b1;
                           state_q <= DRAIN;
                        end
                     end else begin
                        shadow_q <= shadow_d;
                        cnt_q    <= beatIdx + CNT_W'(1);
                        state_q  <= LOAD;
                     end
                  end
               end
               APPLY: begin
                  cfg_q   <= shadow_q;
                  cset_q  <= 1'b1;
                  state_q <= IDLE;
               end
               DRAIN: begin
                  if (acceptBeat && in_last) begin
                     state_q <= IDLE;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Scoreboard bench for mac_cfg_loader: the stimulus thread pushes the
// expected committed cfg words and expected err pulses; a negedge monitor
// pops and compares whenever cset or err appears.
module tb_mac_cfg_loader;

   localparam int CW = 132;

   // Hand-computed commit words: beat k lands in bits [8k+7:8k], and only
   // the low nibble of beat 16 fits under bit 132
   localparam logic [CW-1:0] FRAME_01 = 132'h1_10_0F_0E_0D_0C_0B_0A_09_08_07_06_05_04_03_02_01;
   localparam logic [CW-1:0] FRAME_A0 = 132'h0_AF_AE_AD_AC_AB_AA_A9_A8_A7_A6_A5_A4_A3_A2_A1_A0;
   localparam logic [CW-1:0] FRAME_31 = 132'h1_40_3F_3E_3D_3C_3B_3A_39_38_37_36_35_34_33_32_31;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_data;
   logic          in_last;
   logic [CW-1:0] cfg;
   logic          cset;
   logic          busy;
   logic          err;

   int            cyc = 0;
   int            passCnt = 0;
   int            totalCnt = 0;
   int            errPend = 0;
   int            lastAcceptCyc = 0;
   int            acceptCyc;
   logic          prevCset = 1'b0;
   logic [CW-1:0] expCfgQ[$];
   int            csetCycleQ[$];

   mac_cfg_loader dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .cfg      (cfg),
      .cset     (cset),
      .busy     (busy),
      .err      (err)
   );

   // Free-running clock and a cycle counter for latency/spacing checks
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      totalCnt++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         passCnt++;
      end
   endtask

   // Offer one beat and hold it until the DUT takes it (bounded)
   task automatic applyStimulus(input logic [7:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      for (int g = 0; g < 50 && !ok; g++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         totalCnt++;
         $display("[TB] FAIL beatTimeout: beat %h never accepted, expected acceptance within 50 cycles", d);
      end
      lastAcceptCyc = cyc;
   endtask

   // Beats start+first .. start+n-1, in_last on index lastAt (-1 for none)
   task automatic sendFrame(input logic [7:0] start, input int first, input int n, input int lastAt);
      for (int i = first; i < n; i++) begin
         applyStimulus(start + 8'(i), (i == lastAt));
      end
   endtask

   task automatic idleCycles(input int n);
      in_valid = 1'b0;
      in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: pop expected commits on cset, account for err pulses
   always @(negedge clk) begin
      if (rst) begin
         if (cset) begin
            if (prevCset) begin
               totalCnt++;
               $display("[TB] FAIL csetBackToBack: cset high on consecutive cycles, expected single-cycle pulse");
            end
            csetCycleQ.push_back(cyc);
            if (expCfgQ.size() == 0) begin
               totalCnt++;
               $display("[TB] FAIL unexpectedCset: commit of cfg %h, expected no commit", cfg);
            end else begin
               checkOutput("cfgCommit", cfg, expCfgQ.pop_front());
            end
         end
         if (err) begin
            checkOutput("errExpected", CW'(errPend > 0), CW'(1));
            if (errPend > 0) errPend--;
         end
      end
      prevCset = cset;
   end

   // Global guard so a stuck run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed stimulus sequence
   initial begin
      rst      = 1'b0;
      en       = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("resetReady", CW'(in_ready), CW'(0));
      checkOutput("resetCfg",   cfg,           '0);
      checkOutput("resetBusy",  CW'(busy),     CW'(0));
      checkOutput("resetCset",  CW'(cset),     CW'(0));
      checkOutput("resetErr",   CW'(err),      CW'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("readyAfterReset", CW'(in_ready), CW'(1));
      @(posedge clk);
      #1;

      // Nominal frame 0x01..0x11
      $display("[TB] nominal frame");
      expCfgQ.push_back(FRAME_01);
      sendFrame(8'h01, 0, 17, 16);
      acceptCyc = lastAcceptCyc;
      idleCycles(3);
      @(negedge clk);
      checkOutput("cfgLowByte",   CW'(cfg[7:0]),     CW'(8'h01));
      checkOutput("cfgConfBits",  CW'(cfg[131:128]), CW'(4'h1));
      checkOutput("idleBusy",     CW'(busy),         CW'(0));
      if (csetCycleQ.size() == 0) begin
         totalCnt++;
         $display("[TB] FAIL csetLatency: no cset seen, expected one cycle after last beat");
      end else begin
         checkOutput("csetLatency", CW'(csetCycleQ[$] - acceptCyc), CW'(1));
      end
      idleCycles(1);

      // Early in_last on beat 5
      $display("[TB] early last");
      errPend++;
      sendFrame(8'h77, 0, 5, 4);
      idleCycles(3);
      @(negedge clk);
      checkOutput("cfgHeldEarlyLast", cfg,            FRAME_01);
      checkOutput("earlyLastErrSeen", CW'(errPend),   CW'(0));
      checkOutput("earlyLastIdle",    CW'(busy),      CW'(0));
      idleCycles(1);
      expCfgQ.push_back(FRAME_A0);
      sendFrame(8'hA0, 0, 17, 16);
      idleCycles(3);

      // Missing in_last: drain three beats
      $display("[TB] missing last / drain");
      errPend++;
      sendFrame(8'h50, 0, 17, -1);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("drainBusy", CW'(busy), CW'(1));
      idleCycles(1);
      sendFrame(8'h60, 0, 3, 2);
      idleCycles(3);
      @(negedge clk);
      checkOutput("drainIdle",     CW'(busy),    CW'(0));
      checkOutput("drainCfgHeld",  cfg,          FRAME_A0);
      checkOutput("drainErrOnce",  CW'(errPend), CW'(0));
      idleCycles(1);

      // Enable dropped for 4 cycles before beat 9
      $display("[TB] enable gap");
      expCfgQ.push_back(FRAME_31);
      sendFrame(8'h31, 0, 8, -1);
      en       = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h39;
      in_last  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("enLowReady", CW'(in_ready), CW'(0));
         checkOutput("enLowBusy",  CW'(busy),     CW'(1));
         @(posedge clk);
         #1;
      end
      en = 1'b1;
      sendFrame(8'h31, 8, 17, 16);
      idleCycles(3);
      @(negedge clk);
      checkOutput("cfgAfterEnGap", cfg, FRAME_31);
      idleCycles(1);

      // Reset in the middle of a frame
      $display("[TB] reset mid-frame");
      sendFrame(8'h55, 0, 12, -1);
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midResetCfg",   cfg,           '0);
      checkOutput("midResetBusy",  CW'(busy),     CW'(0));
      checkOutput("midResetReady", CW'(in_ready), CW'(0));
      @(posedge clk);
      #1 rst = 1'b1;
      idleCycles(1);
      expCfgQ.push_back(FRAME_A0);
      sendFrame(8'hA0, 0, 17, 16);
      idleCycles(3);
      @(negedge clk);
      checkOutput("cfgAfterReset", cfg, FRAME_A0);
      idleCycles(1);

      // Back-to-back frames with in_valid held high
      $display("[TB] back-to-back");
      expCfgQ.push_back(FRAME_01);
      expCfgQ.push_back(FRAME_31);
      sendFrame(8'h01, 0, 17, 16);
      sendFrame(8'h31, 0, 17, 16);
      idleCycles(4);
      @(negedge clk);
      if (csetCycleQ.size() < 2) begin
         totalCnt++;
         $display("[TB] FAIL csetSpacing: only %0d commits seen, expected two", csetCycleQ.size());
      end else begin
         checkOutput("csetSpacing", CW'(csetCycleQ[$] - csetCycleQ[$-1]), CW'(18));
      end
      checkOutput("cfgSecondFrame", cfg, FRAME_31);
      idleCycles(2);

      @(negedge clk);
      checkOutput("scoreboardDrained", CW'(expCfgQ.size()), CW'(0));
      checkOutput("errDrained",        CW'(errPend),        CW'(0));

      $display("%0d/%0d checks passed", passCnt, totalCnt);
      $finish;
   end

endmodule

// File: doc/mac_cfg_loader.md
MAC_CFG_LOADER -- requirements
Module: mac_cfg_loader

Interface
REQ-001 SHALL have parameter MAC_CONF_WIDTH, default 4: mode bits (signed, mac/mul, 2-bit Single/Dual/Quad).
REQ-002 SHALL have parameter MAC_ACC_WIDTH, default 32: per-block accumulator init width.
REQ-003 SHALL have parameter BEAT_WIDTH, default 8: serial input beat width.
REQ-004 SHALL have derived localparam CFG_WIDTH = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH (132) and NBEATS = ceil(CFG_WIDTH/BEAT_WIDTH) (17).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port en, input, 1 bit: stage enable; low freezes all state.
REQ-008 SHALL have port in_valid, input, 1 bit: beat valid.
REQ-009 SHALL have port in_ready, output, 1 bit: beat accepted when in_valid & in_ready & en.
REQ-010 SHALL have port in_data, input, BEAT_WIDTH bits: config beat, LSB chunk first.
REQ-011 SHALL have port in_last, input, 1 bit: marks final beat of a frame.
REQ-012 SHALL have port cfg, output, CFG_WIDTH bits: registered config to mac_cluster cfg bus.
REQ-013 SHALL have port cset, output, 1 bit: one-cycle commit strobe to mac_cluster cset.
REQ-014 SHALL have port busy, output, 1 bit: high in any state except IDLE.
REQ-015 SHALL have port err, output, 1 bit: one-cycle pulse on a malformed frame.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, APPLY, DRAIN.
REQ-017 IDLE: in_ready=1; an accepted beat SHALL write chunk 0, set beat counter to 1, and go to LOAD, except when in_last=1 (see REQ-021).
REQ-018 LOAD: in_ready=1; an accepted beat SHALL write shadow[cnt*BEAT_WIDTH +: BEAT_WIDTH] and increment cnt; bits at or above CFG_WIDTH in the final beat SHALL be discarded.
REQ-019 Frame complete: the beat with index NBEATS-1 accepted together with in_last=1 -> APPLY.
REQ-020 APPLY: in_ready=0; cfg <= shadow; cset=1 for exactly this cycle (registered, so cfg and cset change on the same edge); next state IDLE.
REQ-021 in_last=1 on any beat with index < NBEATS-1 -> err pulse next cycle, shadow discarded, cnt cleared, next state IDLE, cfg unchanged.
REQ-022 Beat index NBEATS-1 accepted with in_last=0 -> err pulse next cycle, go to DRAIN, cfg unchanged.
REQ-023 DRAIN: in_ready=1; accepted beats SHALL be dropped; an accepted beat with in_last=1 -> IDLE with no further err.
REQ-024 en=0: in_ready=0, no state, counter, shadow or output change; cset and err SHALL be 0; a pending APPLY SHALL complete on the first cycle with en=1.
REQ-025 cfg SHALL hold its value between commits; cset SHALL never be asserted on consecutive cycles.
REQ-026 Throughput: one beat per cycle; minimum frame-to-frame spacing is NBEATS+1 cycles.
REQ-027 in_data and in_last SHALL be ignored when in_valid=0.

Reset
REQ-028 rst low SHALL asynchronously set state=IDLE, cnt=0, shadow=0, cfg=0, cset=0, err=0, busy=0.
REQ-029 in_ready SHALL be 0 while rst is low and 1 in the first cycle after release.
REQ-030 Reset during LOAD or APPLY SHALL abort the frame; no cset SHALL be emitted for it.

Structure
REQ-031 MAC_CONF_WIDTH, MAC_ACC_WIDTH and the CFG_WIDTH formula SHALL come from mac_const.vh, shared with mac_cluster.
REQ-032 The FSM state encodings SHALL be localparams inside the module.
REQ-033 The block SHALL be a single flat module with no sub-modules; its output SHALL connect directly to mac_cluster cfg/cset.

Verification
REQ-034 Nominal frame: 17 beats 0x01..0x11 with in_last on beat 17 -> cset pulses once, 1 cycle after beat 17; cfg[7:0]=0x01, cfg[131:128]=0x1.
REQ-035 Early in_last on beat 5 -> err pulse, no cset, cfg retains its prior value, next 17-beat frame commits correctly.
REQ-036 17 beats without in_last, then 3 beats with in_last on the third -> err once, DRAIN, return to IDLE, no cset.
REQ-037 en dropped for 4 cycles mid-frame at beat 9 -> in_ready=0 during that window; frame completes and cfg matches an uninterrupted load.
REQ-038 rst asserted in LOAD at beat 12 -> cfg=0, no cset; a fresh frame afterwards commits.
REQ-039 Two back-to-back frames with in_valid held high -> cset pulses spaced exactly 18 cycles apart; cfg reflects each frame in turn.
